// File: rtl/audio_pkg.sv
// Shared types and scaling arithmetic for the playback sample packer.
package audio_pkg;

   typedef enum logic [1:0] {
      WL_16 = 2'b00,
      WL_20 = 2'b01,
      WL_24 = 2'b10,
      WL_32 = 2'b11
   } wl_e;

   // Packer control flow: collect left, collect right, scale, push to FIFO.
   typedef enum logic [1:0] {
      S_LEFT  = 2'd0,
      S_RIGHT = 2'd1,
      S_SCALE = 2'd2,
      S_PUSH  = 2'd3
   } state_e;

   localparam logic [8:0] GAIN_UNITY = 9'd256;

   typedef struct packed {
      logic [31:0] right;
      logic [31:0] left;
   } frame_t;

   typedef struct packed {
      logic        clip;
      logic [31:0] value;
   } scaled_t;

   function automatic logic [5:0] wl_bits(input wl_e wl);
      case (wl)
         WL_16:   return 6'd16;
         WL_20:   return 6'd20;
         WL_24:   return 6'd24;
         default: return 6'd32;
      endcase
   endfunction

   // Gain is Q1.8 (256 = unity); the product is floored by the arithmetic
   // shift and then clamped to the signed range of the active word length.
   function automatic scaled_t scale_sat(input logic [31:0] sample,
                                         input logic [8:0]  gain,
                                         input wl_e         wl);
      logic signed [41:0] s_ext;
      logic signed [41:0] g_ext;
      logic signed [41:0] p;
      logic signed [41:0] q;
      logic signed [41:0] hi;
      logic signed [41:0] lo;
      scaled_t            r;
      s_ext = 42'($signed(sample));
      g_ext = $signed({33'd0, gain});
      p     = s_ext * g_ext;
      q     = p >>> 8;
      hi    = (42'sd1 <<< (wl_bits(wl) - 6'd1)) - 42'sd1;
      lo    = ~hi;
      r.clip  = 1'b0;
      r.value = q[31:0];
      if (q > hi) begin
         r.clip  = 1'b1;
         r.value = hi[31:0];
      end else if (q < lo) begin
         r.clip  = 1'b1;
         r.value = lo[31:0];
      end
      return r;
   endfunction

endpackage

// File: rtl/audio_sample_packer_if.sv
// Input sample stream and output frame stream of the packer.
// Handshake: a beat transfers on a cycle where valid and ready are both high
// at the rising clock edge; valid, once raised, holds with stable data until
// that transfer, and ready may be asserted independently of valid.
interface audio_sample_packer_if;
   logic        s_axis_tvalid;
   logic        s_axis_tready;
   logic [31:0] s_axis_tdata;
   logic        m_axis_tvalid;
   logic        m_axis_tready;
   logic [63:0] m_axis_tdata;

   modport master (
      output s_axis_tvalid, s_axis_tdata, m_axis_tready,
      input  s_axis_tready, m_axis_tvalid, m_axis_tdata
   );

   modport slave (
      input  s_axis_tvalid, s_axis_tdata, m_axis_tready,
      output s_axis_tready, m_axis_tvalid, m_axis_tdata
   );
endinterface

// File: rtl/audio_frame_fifo.sv
// First-word fall-through frame FIFO; head entry is visible while not empty.
module audio_frame_fifo #(
   parameter int DEPTH = 4,
   parameter int WIDTH = 64,
   localparam int AW   = $clog2(DEPTH)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             push,
   input  logic [WIDTH-1:0] wdata,
   input  logic             pop,
   output logic [WIDTH-1:0] rdata,
   output logic             full,
   output logic             empty,
   output logic [AW:0]      level
);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wr_ptr;
   logic [AW-1:0]    rd_ptr;
   logic             do_pop;
   logic             do_push;

   assign full    = (level == (AW+1)'(DEPTH));
   assign empty   = (level == '0);
   assign do_pop  = pop & ~empty;
   // A pop in the same cycle frees the slot, so a full FIFO still accepts.
   assign do_push = push & (~full | do_pop);
   assign rdata   = empty ? '0 : mem[rd_ptr];

   // Storage write; contents need no reset because empty masks the output.
   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr] <= wdata;
   end

   // Pointer and occupancy bookkeeping; pointers wrap at the power-of-two depth.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         level  <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + AW'(1);
         if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
         case ({do_push, do_pop})
            2'b10:   level <= level + (AW+1)'(1);
            2'b01:   level <= level - (AW+1)'(1);
            default: level <= level;
         endcase
      end
   end

endmodule

// File: rtl/audio_sample_packer.sv
// Pairs left/right samples, applies per-channel gain with saturation and
// queues stereo frames for the playback serializer.
module audio_sample_packer
   import audio_pkg::*;
#(
   parameter int FIFO_DEPTH = 4,
   parameter int SAT_CNT_W  = 16
) (
   input  logic                          ac_bclk,
   input  logic                          ac_resetn,
   audio_sample_packer_if.slave          axis,
   input  logic [1:0]                    word_length,
   input  logic [8:0]                    gain_left,
   input  logic [8:0]                    gain_right,
   input  logic                          mute,
   input  logic                          sat_clear,
   output logic [SAT_CNT_W-1:0]          sat_count,
   output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
   output state_e                        fsm_state
);

   state_e      state;
   state_e      state_nxt;
   logic        run;
   logic        in_fire;
   logic        push;
   logic        pop;
   logic        full;
   logic        empty;
   logic [31:0] left_q;
   logic [31:0] right_q;
   wl_e         wl_q;
   logic [8:0]  gain_l_q;
   logic [8:0]  gain_r_q;
   logic        mute_q;
   frame_t      frame_q;
   scaled_t     sl;
   scaled_t     sr;
   logic [1:0]  sat_inc;
   logic [SAT_CNT_W:0] sat_sum;

   assign fsm_state          = state;
   assign in_fire            = axis.s_axis_tvalid & axis.s_axis_tready;
   assign pop                = axis.m_axis_tvalid & axis.m_axis_tready;
   assign axis.m_axis_tvalid = ~empty;
   assign sl                 = scale_sat(left_q,  gain_l_q, wl_q);
   assign sr                 = scale_sat(right_q, gain_r_q, wl_q);

   // Ready comes up one cycle after reset release.
   always_ff @(posedge ac_bclk or negedge ac_resetn) begin
      if (!ac_resetn) run <= 1'b0;
      else            run <= 1'b1;
   end

   // FSM state register.
   always_ff @(posedge ac_bclk or negedge ac_resetn) begin
      if (!ac_resetn) state <= S_LEFT;
      else            state <= state_nxt;
   end

   // FSM next-state logic.
   always_comb begin
      state_nxt = state;
      case (state)
         S_LEFT:  if (in_fire) state_nxt = S_RIGHT;
         S_RIGHT: if (in_fire) state_nxt = S_SCALE;
         S_SCALE: state_nxt = S_PUSH;
         S_PUSH:  if (push) state_nxt = S_LEFT;
         default: state_nxt = S_LEFT;
      endcase
   end

   // FSM outputs: input ready while collecting, FIFO write while pushing.
   always_comb begin
      axis.s_axis_tready = 1'b0;
      push               = 1'b0;
      case (state)
         S_LEFT, S_RIGHT: axis.s_axis_tready = run;
         S_PUSH:          push = ~full | pop;
         default: ;
      endcase
   end

   // Sample capture, control latching at the right handshake, scaled frame.
   always_ff @(posedge ac_bclk or negedge ac_resetn) begin
      if (!ac_resetn) begin
         left_q   <= '0;
         right_q  <= '0;
         wl_q     <= WL_16;
         gain_l_q <= GAIN_UNITY;
         gain_r_q <= GAIN_UNITY;
         mute_q   <= 1'b0;
         frame_q  <= '0;
      end else begin
         if (state == S_LEFT && in_fire) left_q <= axis.s_axis_tdata;
         if (state == S_RIGHT && in_fire) begin
            right_q  <= axis.s_axis_tdata;
            wl_q     <= wl_e'(word_length);
            gain_l_q <= gain_left;
            gain_r_q <= gain_right;
            mute_q   <= mute;
         end
         if (state == S_SCALE) begin
            if (mute_q) frame_q <= '0;
            else        frame_q <= '{right: sr.value, left: sl.value};
         end
      end
   end

   assign sat_inc = (state == S_SCALE && !mute_q) ? ({1'b0, sl.clip} + {1'b0, sr.clip}) : 2'd0;
   assign sat_sum = {1'b0, sat_count} + (SAT_CNT_W+1)'(sat_inc);

   // Clip event counter: clear wins, otherwise add and stick at all-ones.
   always_ff @(posedge ac_bclk or negedge ac_resetn) begin
      if (!ac_resetn)             sat_count <= '0;
      else if (sat_clear)         sat_count <= '0;
      else if (sat_sum[SAT_CNT_W]) sat_count <= '1;
      else                        sat_count <= sat_sum[SAT_CNT_W-1:0];
   end

   audio_frame_fifo #(
      .DEPTH (FIFO_DEPTH),
      .WIDTH (64)
   ) u_fifo (
      .clk   (ac_bclk),
      .rst_n (ac_resetn),
      .push  (push),
      .wdata (frame_q),
      .pop   (pop),
      .rdata (axis.m_axis_tdata),
      .full  (full),
      .empty (empty),
      .level (fifo_level)
   );

endmodule

// File: tb/tb_audio_sample_packer.sv
// Directed bench for the stereo sample packer.
module tb_audio_sample_packer;
   import audio_pkg::*;

   logic        ac_bclk;
   logic        ac_resetn;
   logic [1:0]  word_length;
   logic [8:0]  gain_left;
   logic [8:0]  gain_right;
   logic        mute;
   logic        sat_clear;
   logic [15:0] sat_count;
   logic [2:0]  fifo_level;
   state_e      fsm_state;
   int          checks;
   int          errors;

   audio_sample_packer_if bus ();

   audio_sample_packer #(
      .FIFO_DEPTH (4),
      .SAT_CNT_W  (16)
   ) dut (
      .ac_bclk     (ac_bclk),
      .ac_resetn   (ac_resetn),
      .axis        (bus),
      .word_length (word_length),
      .gain_left   (gain_left),
      .gain_right  (gain_right),
      .mute        (mute),
      .sat_clear   (sat_clear),
      .sat_count   (sat_count),
      .fifo_level  (fifo_level),
      .fsm_state   (fsm_state)
   );

   // Clock
   initial begin
      ac_bclk = 1'b0;
      forever #5 ac_bclk = ~ac_bclk;
   end

   // Watchdog
   initial begin
      #200000;
      $display("FAIL watchdog run did not complete");
      $fatal(1, "watchdog");
   end

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic send_word(input logic [31:0] d);
      int n;
      n = 0;
      bus.s_axis_tvalid = 1'b1;
      bus.s_axis_tdata  = d;
      @(negedge ac_bclk);
      while (!bus.s_axis_tready && n < 50) begin
         @(negedge ac_bclk);
         n++;
      end
      if (n >= 50) check("send_timeout", 64'(n), 64'd0);
      @(posedge ac_bclk);
      #1;
      bus.s_axis_tvalid = 1'b0;
   endtask

   task automatic send_frame(input logic [31:0] l, input logic [31:0] r);
      send_word(l);
      send_word(r);
   endtask

   task automatic pop_frame(input string tag, input logic [63:0] exp);
      int n;
      n = 0;
      @(negedge ac_bclk);
      while (!bus.m_axis_tvalid && n < 50) begin
         @(negedge ac_bclk);
         n++;
      end
      if (n >= 50) check({tag, "_timeout"}, 64'(n), 64'd0);
      check(tag, bus.m_axis_tdata, exp);
      bus.m_axis_tready = 1'b1;
      @(posedge ac_bclk);
      #1;
      bus.m_axis_tready = 1'b0;
   endtask

   initial begin
      checks = 0;
      errors = 0;
      ac_resetn         = 1'b0;
      bus.s_axis_tvalid = 1'b0;
      bus.s_axis_tdata  = '0;
      bus.m_axis_tready = 1'b0;
      word_length = 2'b00;
      gain_left   = GAIN_UNITY;
      gain_right  = GAIN_UNITY;
      mute        = 1'b0;
      sat_clear   = 1'b0;

      // Reset state
      #3;
      check("rst_s_tready", 64'(bus.s_axis_tready), 64'd0);
      check("rst_m_tvalid", 64'(bus.m_axis_tvalid), 64'd0);
      check("rst_m_tdata",  bus.m_axis_tdata, 64'd0);
      check("rst_level",    64'(fifo_level), 64'd0);
      check("rst_sat",      64'(sat_count), 64'd0);
      check("rst_state",    64'(fsm_state), 64'(S_LEFT));
      @(negedge ac_bclk);
      ac_resetn = 1'b1;
      @(posedge ac_bclk);
      #1;
      check("rel_s_tready", 64'(bus.s_axis_tready), 64'd1);

      // Unity pass-through with latency trace
      send_frame(32'h0000_1234, 32'hFFFF_EDCC);
      @(negedge ac_bclk);
      check("lat1_tvalid", 64'(bus.m_axis_tvalid), 64'd0);
      check("lat1_state",  64'(fsm_state), 64'(S_SCALE));
      check("lat1_ready",  64'(bus.s_axis_tready), 64'd0);
      @(negedge ac_bclk);
      check("lat2_tvalid", 64'(bus.m_axis_tvalid), 64'd0);
      check("lat2_state",  64'(fsm_state), 64'(S_PUSH));
      @(negedge ac_bclk);
      check("lat3_tvalid", 64'(bus.m_axis_tvalid), 64'd1);
      check("lat3_level",  64'(fifo_level), 64'd1);
      pop_frame("unity", 64'hFFFFEDCC_00001234);
      check("unity_level", 64'(fifo_level), 64'd0);
      check("unity_sat",   64'(sat_count), 64'd0);

      // Positive and negative clip at 16 bits
      gain_left = 9'd511;
      send_frame(32'h0000_7000, 32'h0000_0000);
      pop_frame("pos_clip", 64'h00000000_00007FFF);
      check("pos_clip_sat", 64'(sat_count), 64'd1);
      send_frame(32'hFFFF_8000, 32'h0000_0000);
      pop_frame("neg_clip", 64'h00000000_FFFF8000);
      check("neg_clip_sat", 64'(sat_count), 64'd2);
      gain_right = 9'd511;
      send_frame(32'h0000_7000, 32'h0000_7000);
      pop_frame("both_clip", 64'h00007FFF_00007FFF);
      check("both_clip_sat", 64'(sat_count), 64'd4);

      // Counter clear
      sat_clear = 1'b1;
      @(posedge ac_bclk);
      #1;
      sat_clear = 1'b0;
      check("sat_clear", 64'(sat_count), 64'd0);

      // Half gain floors toward minus infinity
      word_length = 2'b10;
      gain_left   = 9'd128;
      gain_right  = 9'd128;
      send_frame(32'hFFFF_FFFF, 32'h0000_0003);
      pop_frame("half_floor", 64'h00000001_FFFFFFFF);
      check("half_sat", 64'(sat_count), 64'd0);

      // Full 32-bit range clip on both channels
      word_length = 2'b11;
      gain_left   = 9'd511;
      gain_right  = 9'd511;
      send_frame(32'h7FFF_FFFF, 32'h8000_0000);
      pop_frame("wl32_clip", 64'h80000000_7FFFFFFF);
      check("wl32_sat", 64'(sat_count), 64'd2);

      // 20-bit boundaries: one above max clips, exact min passes
      word_length = 2'b01;
      gain_left   = GAIN_UNITY;
      gain_right  = GAIN_UNITY;
      send_frame(32'h0008_0000, 32'hFFF8_0000);
      pop_frame("wl20_edge", 64'hFFF80000_0007FFFF);
      check("wl20_sat", 64'(sat_count), 64'd3);

      // Mute zeroes the frame and suppresses clip counting
      word_length = 2'b00;
      gain_left   = 9'd511;
      mute        = 1'b1;
      send_frame(32'h0000_7000, 32'h0000_1234);
      pop_frame("mute", 64'h0);
      check("mute_sat", 64'(sat_count), 64'd3);

      // Controls sampled only at the right handshake
      word_length = 2'b11;
      send_word(32'h0000_7000);
      word_length = 2'b00;
      mute        = 1'b0;
      send_word(32'h0000_0000);
      mute        = 1'b1;
      pop_frame("ctl_capture", 64'h00000000_00007FFF);
      check("ctl_sat", 64'(sat_count), 64'd4);
      mute      = 1'b0;
      gain_left = GAIN_UNITY;

      // Backpressure: five frames into a four-deep FIFO
      for (int i = 0; i < 5; i++) begin
         send_frame(32'(i * 16 + 1), 32'(i * 16 + 2));
      end
      repeat (3) @(negedge ac_bclk);
      check("bp_level", 64'(fifo_level), 64'd4);
      check("bp_state", 64'(fsm_state), 64'(S_PUSH));
      check("bp_ready", 64'(bus.s_axis_tready), 64'd0);
      pop_frame("bp_f0", 64'h00000002_00000001);
      check("bp_level_swap", 64'(fifo_level), 64'd4);
      pop_frame("bp_f1", 64'h00000012_00000011);
      pop_frame("bp_f2", 64'h00000022_00000021);
      pop_frame("bp_f3", 64'h00000032_00000031);
      pop_frame("bp_f4", 64'h00000042_00000041);
      check("bp_drained", 64'(fifo_level), 64'd0);

      // Reset mid-frame discards FIFO and held left sample
      send_frame(32'h0000_0010, 32'h0000_0020);
      repeat (3) @(negedge ac_bclk);
      check("pre_rst_level", 64'(fifo_level), 64'd1);
      send_word(32'h0000_1111);
      @(negedge ac_bclk);
      ac_resetn = 1'b0;
      #1;
      check("mid_rst_tvalid", 64'(bus.m_axis_tvalid), 64'd0);
      check("mid_rst_level",  64'(fifo_level), 64'd0);
      check("mid_rst_state",  64'(fsm_state), 64'(S_LEFT));
      check("mid_rst_sat",    64'(sat_count), 64'd0);
      @(negedge ac_bclk);
      ac_resetn = 1'b1;
      @(posedge ac_bclk);
      #1;
      send_frame(32'h0000_2222, 32'h0000_3333);
      pop_frame("post_rst", 64'h00003333_00002222);
      check("post_rst_level", 64'(fifo_level), 64'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
